reg_dest_pipeline: RTL and testbench

//  Parametrised successor of the register-destination mux: selects the write

---
 rtl/reg_dest_pipeline.sv | 98 +++++++++
 tb/tb_reg_dest_pipeline.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dest_pipeline.sv
// Register-destination select plus a STAGES-deep writeback shift pipeline
// with RAW hazard detection against every in-flight destination.
module reg_dest_pipeline #(
  parameter int ADDR_W       = 5,
  parameter int STAGES       = 3,
  parameter int FLUSH_STAGES = 1,
  parameter int SP_REG       = 29,
  parameter int FP_REG       = 30,
  parameter int RA_REG       = 31,
  localparam int HW          = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        seletor_regdest,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic              wr_en_in,
  input  logic              advance,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic [ADDR_W-1:0] mux_RegDest_output,
  output logic [ADDR_W-1:0] dest_out,
  output logic              wr_en_out,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [HW-1:0]     hit_stage_a,
  output logic [HW-1:0]     hit_stage_b
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
  } stage_t;

  logic   legal;
  stage_t entry;
  stage_t stg  [1:STAGES];
  stage_t prev [1:STAGES];

  always_comb begin
    legal              = 1'b1;
    mux_RegDest_output = '0;
    unique case (seletor_regdest)
      3'b000:  mux_RegDest_output = RT;
      3'b001:  mux_RegDest_output = RD;
      3'b010:  mux_RegDest_output = ADDR_W'(SP_REG);
      3'b011:  mux_RegDest_output = ADDR_W'(FP_REG);
      3'b100:  mux_RegDest_output = ADDR_W'(RA_REG);
      default: legal = 1'b0;
    endcase
  end

  // $zero is never written, so it is never tracked either
  always_comb begin
    entry.valid = wr_en_in & legal & (mux_RegDest_output != '0);
    entry.dest  = entry.valid ? mux_RegDest_output : '0;
  end

  assign prev[1] = entry;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam bit KILL = (k <= FLUSH_STAGES);

    if (k > 1) begin : g_link
      assign prev[k] = stg[k-1];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stg[k] <= '0;
      end else if (KILL && flush) begin
        stg[k] <= '0;
      end else if (advance) begin
        stg[k] <= prev[k];
      end
    end
  end

  assign dest_out  = stg[STAGES].dest;
  assign wr_en_out = stg[STAGES].valid;

  // Scan oldest to youngest so the nearest stage wins
  always_comb begin
    hit_stage_a = '0;
    hit_stage_b = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (stg[k].valid && src_a != '0 && stg[k].dest == src_a)
        hit_stage_a = HW'(k);
      if (stg[k].valid && src_b != '0 && stg[k].dest == src_b)
        hit_stage_b = HW'(k);
    end
  end

  assign hazard_a = (hit_stage_a != '0);
  assign hazard_b = (hit_stage_b != '0);

endmodule

// File: tb/tb_reg_dest_pipeline.sv
// Randomised and directed check of reg_dest_pipeline against a
// behavioural model of the destination pipeline.
module tb_reg_dest_pipeline;

  localparam int AW = 5;
  localparam int S  = 3;
  localparam int F  = 1;
  localparam int HW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    sel;
  logic [AW-1:0] rt, rd, src_a, src_b;
  logic          wr_en_in, advance, flush;
  logic [AW-1:0] mux_out, dest_out;
  logic          wr_en_out, hazard_a, hazard_b;
  logic [HW-1:0] hit_a, hit_b;

  int n_chk  = 0;
  int n_fail = 0;

  bit          mv [1:S];
  int unsigned md [1:S];

  reg_dest_pipeline #(
    .ADDR_W(AW), .STAGES(S), .FLUSH_STAGES(F)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .seletor_regdest    (sel),
    .RT                 (rt),
    .RD                 (rd),
    .wr_en_in           (wr_en_in),
    .advance            (advance),
    .flush              (flush),
    .src_a              (src_a),
    .src_b              (src_b),
    .mux_RegDest_output (mux_out),
    .dest_out           (dest_out),
    .wr_en_out          (wr_en_out),
    .hazard_a           (hazard_a),
    .hazard_b           (hazard_b),
    .hit_stage_a        (hit_a),
    .hit_stage_b        (hit_b)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned pick();
    case (sel)
      3'd0:    return rt;
      3'd1:    return rd;
      3'd2:    return 29;
      3'd3:    return 30;
      3'd4:    return 31;
      default: return 0;
    endcase
  endfunction

  function automatic bit ent_ok();
    return wr_en_in && sel <= 3'd4 && pick() != 0;
  endfunction

  function automatic int unsigned nearest(int unsigned src);
    if (src == 0) return 0;
    for (int k = 1; k <= S; k++)
      if (mv[k] && md[k] == src) return k;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= S; k++) begin
      mv[k] = 0;
      md[k] = 0;
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [AW-1:0] t,
                       input logic [AW-1:0] d, input logic w,
                       input logic a, input logic f,
                       input logic [AW-1:0] sa, input logic [AW-1:0] sb);
    sel = s; rt = t; rd = d; wr_en_in = w;
    advance = a; flush = f; src_a = sa; src_b = sb;
  endtask

  task automatic check_all();
    int unsigned ha, hb;
    #1;
    ha = nearest(src_a);
    hb = nearest(src_b);
    chk("mux", mux_out, pick());
    chk("dest_out", dest_out, mv[S] ? md[S] : 0);
    chk("wr_en_out", wr_en_out, mv[S]);
    chk("hazard_a", hazard_a, ha != 0);
    chk("hazard_b", hazard_b, hb != 0);
    chk("hit_a", hit_a, ha);
    chk("hit_b", hit_b, hb);
  endtask

  task automatic tick();
    bit          ov [1:S];
    int unsigned od [1:S];
    bit          ev;
    int unsigned ed;
    ev = ent_ok();
    ed = ev ? pick() : 0;
    for (int k = 1; k <= S; k++) begin
      ov[k] = mv[k];
      od[k] = md[k];
    end
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      for (int k = 1; k <= S; k++) begin
        if (flush && k <= F) begin
          mv[k] = 0; md[k] = 0;
        end else if (advance) begin
          mv[k] = (k == 1) ? ev : ov[k-1];
          md[k] = (k == 1) ? ed : od[k-1];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_wr_en", wr_en_out, 0);
    reset = 1'b1;

    // Test 2: RD=7 reaches writeback on the third advancing edge
    drive(3'd1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, '0, '0);
    tick();
    drive(3'd0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    tick(); check_all();
    chk("t2_early", wr_en_out, 0);
    tick(); check_all();
    chk("t2_dest", dest_out, 7);
    chk("t2_wen", wr_en_out, 1);
    drive(3'd4, '0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    check_all();
    chk("t2_mux_ra", mux_out, 31);
    tick();
    drive(3'd0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    tick(); tick(); check_all();
    chk("t2_ra", dest_out, 31);

    // Test 3: nearest-stage reporting, src 0 never hazards
    drive(3'd0, 5'd8, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    tick();
    drive(3'd0, 5'd0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    tick();
    drive(3'd0, 5'd8, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    tick();
    drive(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0);
    check_all();
    chk("t3_haz_a", hazard_a, 1);
    chk("t3_hit_a", hit_a, 1);
    chk("t3_haz_b", hazard_b, 0);
    chk("t3_wen", wr_en_out, 1);

    // Test 4: hold keeps RT=5 parked in stage 2
    drive(3'd0, 5'd5, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    tick();
    drive(3'd0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    tick();
    drive(3'd0, 5'd6, '0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5);
    for (int i = 0; i < 4; i++) begin
      tick(); check_all();
      chk("t4_hit", hit_a, 2);
    end

    // Test 5: flush kills stage 1 while 9 moves to stage 2
    drive(3'd1, '0, 5'd9, 1'b1, 1'b1, 1'b0, '0, '0);
    tick();
    drive(3'd0, '0, '0, 1'b0, 1'b1, 1'b1, 5'd9, '0);
    tick(); check_all();
    chk("t5_hit", hit_a, 2);
    drive(3'd7, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, '0, '0);
    check_all();
    chk("t5_mux", mux_out, 0);
    tick();
    drive(3'd0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    tick(); tick(); check_all();
    chk("t5_wen", wr_en_out, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] sa, sb;
      sa = ($urandom_range(0, 1) == 1) ? AW'(md[$urandom_range(1, S)])
                                        : AW'($urandom);
      sb = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      drive(3'($urandom_range(0, 7)), AW'($urandom), AW'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, sa, sb);
      check_all();
      tick();
    end

    // Test 1: asynchronous reset mid-stream with all stages valid
    for (int i = 0; i < S; i++) begin
      drive(3'd0, AW'(i + 11), '0, 1'b1, 1'b1, 1'b0, '0, '0);
      tick();
    end
    drive(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd12, 5'd11);
    check_all();
    chk("t1_pre_haz", hazard_a, 1);
    #2 reset = 1'b0;
    #1;
    chk("t1_wen", wr_en_out, 0);
    chk("t1_dest", dest_out, 0);
    chk("t1_haz_a", hazard_a, 0);
    chk("t1_haz_b", hazard_b, 0);
    chk("t1_hit_a", hit_a, 0);
    model_clear();
    drive(3'd0, 5'd3, '0, 1'b1, 1'b1, 1'b0, 5'd3, '0);
    tick(); check_all();
    reset = 1'b1;
    tick(); check_all();
    chk("t1_after", hit_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
